// File: rtl/decay_event_fifo.sv
// decay_event_fifo
//
// Captures double-pulse trigger events into a small FIFO. Each event is
// stored as {time_tag, delta_time}. time_tag is a free-running cycle
// counter, and delta_time is the pulse separation supplied by the trigger
// stage. The block also counts how many events were seen and how many were
// lost to overflow.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   double_trig  level flag from the trigger stage; one event per rising edge
//   delta_time   pulse separation, sampled on the cycle double_trig rises
//   clear        synchronous flush of FIFO contents and statistics
//   rd_en        read request; data appears one cycle later
//   rd_data      {time_tag, delta_time} of the popped entry
//   rd_valid     one-cycle strobe qualifying rd_data
//   empty, full  FIFO occupancy flags
//   level        number of stored entries
//   event_cnt    trigger rising edges since reset or clear (wraps)
//   drop_cnt     events lost because the FIFO was full (saturates)

module decay_event_fifo #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     double_trig,
    input  logic [15:0]              delta_time,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic [TAG_W+15:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              event_cnt,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = TAG_W + 16;
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic              trig_q;
    logic [TAG_W-1:0]  time_tag;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DW-1:0]     mem [DEPTH];

    logic wr_event;
    logic is_empty;
    logic is_full;
    logic do_read;
    logic do_write;
    logic do_drop;

    // On a full FIFO, a write is still accepted when a read happens in the
    // same cycle, because the read frees the slot being written. A read
    // never falls through an empty FIFO. clear overrides everything.
    always_comb begin
        wr_event = double_trig & ~trig_q;
        is_empty = (level == '0);
        is_full  = (level == LEVEL_FULL);
        do_read  = rd_en & ~is_empty & ~clear;
        do_write = wr_event & ~clear & (~is_full | do_read);
        do_drop  = wr_event & ~clear & is_full & ~do_read;
    end

    assign empty = is_empty;
    assign full  = is_full;

    // Storage has no reset so that it maps onto block RAM. When the FIFO is
    // full, wr_ptr equals rd_ptr. The read below then takes the old word
    // before this write replaces it.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= {time_tag, delta_time};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q    <= 1'b0;
            time_tag  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            event_cnt <= '0;
            drop_cnt  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            trig_q   <= double_trig;
            time_tag <= time_tag + TAG_W'(1);

            if (clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                event_cnt <= '0;
                drop_cnt  <= '0;
                rd_valid  <= 1'b0;
            end else begin
                rd_valid <= do_read;

                if (wr_event) begin
                    event_cnt <= event_cnt + 32'd1;
                end

                if (do_drop && drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end

                if (do_write) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end

                if (do_read) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    rd_data <= mem[rd_ptr];
                end

                case ({do_write, do_read})
                    2'b10:   level <= level + (AW+1)'(1);
                    2'b01:   level <= level - (AW+1)'(1);
                    default: level <= level;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decay_event_fifo.sv
// tb_decay_event_fifo
//
// Directed bench for decay_event_fifo with DEPTH=16 and TAG_W=16. Inputs
// change on the falling edge, and outputs are checked on the falling edge
// after each rising edge.

module tb_decay_event_fifo;

    localparam int DEPTH = 16;
    localparam int TAG_W = 16;

    logic               clk;
    logic               rst_n;
    logic               double_trig;
    logic [15:0]        delta_time;
    logic               clear;
    logic               rd_en;
    logic [TAG_W+15:0]  rd_data;
    logic               rd_valid;
    logic               empty;
    logic               full;
    logic [4:0]         level;
    logic [31:0]        event_cnt;
    logic [15:0]        drop_cnt;

    int checkCount = 0;
    int failCount  = 0;

    decay_event_fifo #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .double_trig (double_trig),
        .delta_time  (delta_time),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .event_cnt   (event_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return on the next falling edge.
    task automatic applyStimulus(input logic trig, input logic [15:0] delta,
                                 input logic clr, input logic rd);
        double_trig = trig;
        delta_time  = delta;
        clear       = clr;
        rd_en       = rd;
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        double_trig = 1'b0;
        delta_time  = 16'h0;
        clear       = 1'b0;
        rd_en       = 1'b0;

        #3;
        checkOutput("rst_rd_data",   64'(rd_data),   64'h0);
        checkOutput("rst_rd_valid",  64'(rd_valid),  64'h0);
        checkOutput("rst_level",     64'(level),     64'h0);
        checkOutput("rst_empty",     64'(empty),     64'h1);
        checkOutput("rst_full",      64'(full),      64'h0);
        checkOutput("rst_event_cnt", 64'(event_cnt), 64'h0);
        checkOutput("rst_drop_cnt",  64'(drop_cnt),  64'h0);

        // Release reset on a falling edge. time_tag then reads 0 and
        // increments by one on every rising edge after that.
        @(negedge clk);
        rst_n = 1'b1;

        // Single event captured with time_tag = 100.
        repeat (100) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0123, 1'b0, 1'b0);
        checkOutput("single_level", 64'(level),     64'd1);
        checkOutput("single_evcnt", 64'(event_cnt), 64'd1);
        checkOutput("single_empty", 64'(empty),     64'h0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("single_rd_valid", 64'(rd_valid), 64'h1);
        checkOutput("single_rd_data",  64'(rd_data),  64'h0064_0123);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("single_strobe_end", 64'(rd_valid), 64'h0);
        checkOutput("single_empty_after", 64'(empty),  64'h1);

        // A read on an empty FIFO is ignored, and rd_data holds its value.
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("empty_rd_valid", 64'(rd_valid), 64'h0);
        checkOutput("empty_rd_hold",  64'(rd_data),  64'h0064_0123);
        checkOutput("empty_rd_level", 64'(level),    64'h0);

        // A trigger held high for 50 cycles counts as a single event.
        repeat (50) applyStimulus(1'b1, 16'h0AAA, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("hold_level", 64'(level),     64'd1);
        checkOutput("hold_evcnt", 64'(event_cnt), 64'd2);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("clear_level", 64'(level),     64'd0);
        checkOutput("clear_evcnt", 64'(event_cnt), 64'd0);
        checkOutput("clear_empty", 64'(empty),     64'h1);

        // Overflow test: 20 events with deltas 0x10..0x23 and no reads.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        end
        checkOutput("ovf_full",  64'(full),      64'h1);
        checkOutput("ovf_level", 64'(level),     64'd16);
        checkOutput("ovf_drop",  64'(drop_cnt),  64'd4);
        checkOutput("ovf_evcnt", 64'(event_cnt), 64'd20);

        // With the FIFO full, a write in the same cycle as a read takes the
        // freed slot, and the oldest entry is output.
        applyStimulus(1'b1, 16'h0BEE, 1'b0, 1'b1);
        checkOutput("fullrw_valid", 64'(rd_valid),       64'h1);
        checkOutput("fullrw_delta", 64'(rd_data[15:0]),  64'h0010);
        checkOutput("fullrw_level", 64'(level),          64'd16);
        checkOutput("fullrw_drop",  64'(drop_cnt),       64'd4);
        checkOutput("fullrw_evcnt", 64'(event_cnt),      64'd21);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

        // Drain the FIFO with back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
            checkOutput($sformatf("drain_valid_%0d", i), 64'(rd_valid), 64'h1);
            checkOutput($sformatf("drain_delta_%0d", i), 64'(rd_data[15:0]),
                        (i < 15) ? 64'(16'h0011 + 16'(i)) : 64'h0BEE);
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("drain_empty", 64'(empty),    64'h1);
        checkOutput("drain_level", 64'(level),    64'd0);
        checkOutput("drain_valid", 64'(rd_valid), 64'h0);

        // A write and read in the same cycle on an empty FIFO: the write is
        // accepted and the read is ignored.
        applyStimulus(1'b1, 16'h0055, 1'b0, 1'b1);
        checkOutput("emptyrw_level", 64'(level),    64'd1);
        checkOutput("emptyrw_valid", 64'(rd_valid), 64'h0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0066, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("mid_level_pre", 64'(level), 64'd2);

        // A write and read in the same cycle at a middle level: the level
        // does not change.
        applyStimulus(1'b1, 16'h0077, 1'b0, 1'b1);
        checkOutput("midrw_level", 64'(level),         64'd2);
        checkOutput("midrw_valid", 64'(rd_valid),      64'h1);
        checkOutput("midrw_delta", 64'(rd_data[15:0]), 64'h0055);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

        // Bring the level up to 5, then clear it while a write and a read
        // are also requested. clear wins.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0080 + 16'(i), 1'b0, 1'b0);
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        end
        checkOutput("clrprio_pre_level", 64'(level), 64'd5);
        applyStimulus(1'b1, 16'h0099, 1'b1, 1'b1);
        checkOutput("clrprio_level", 64'(level),     64'd0);
        checkOutput("clrprio_evcnt", 64'(event_cnt), 64'd0);
        checkOutput("clrprio_drop",  64'(drop_cnt),  64'd0);
        checkOutput("clrprio_valid", 64'(rd_valid),  64'h0);
        checkOutput("clrprio_empty", 64'(empty),     64'h1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

        // Assert reset between clock edges with 7 entries stored.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 16'h00A0 + 16'(i), 1'b0, 1'b0);
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        end
        checkOutput("arst_pre_level", 64'(level), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_level",   64'(level),     64'd0);
        checkOutput("arst_empty",   64'(empty),     64'h1);
        checkOutput("arst_full",    64'(full),      64'h0);
        checkOutput("arst_evcnt",   64'(event_cnt), 64'd0);
        checkOutput("arst_rd_data", 64'(rd_data),   64'h0);
        checkOutput("arst_valid",   64'(rd_valid),  64'h0);

        // A trigger that is already high when reset releases counts as a
        // rising edge.
        double_trig = 1'b1;
        delta_time  = 16'h0042;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0);
        checkOutput("postrst_level", 64'(level),     64'd1);
        checkOutput("postrst_evcnt", 64'(event_cnt), 64'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("postrst_delta", 64'(rd_data[15:0]), 64'h0042);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
